// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and default sizing constants.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int FIFO_DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [7:0]    i_wdata,
    input  logic          i_pop,
    output logic [7:0]    o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_last;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_count  = r_count;
    assign o_full   = (r_count == CNT_FULL);
    assign o_empty  = (r_count == {(AW + 1){1'b0}});
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage array: data only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and the last-popped byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
            r_last   <= 8'h00;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // When empty the head keeps showing the byte that was consumed last.
    always_comb begin
        if (o_empty) begin
            o_rdata = r_last;
        end else begin
            o_rdata = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM (8N1, LSB first)
// and a small receive FIFO with overrun and framing-error reporting.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr,
    output logic       o_busy
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_ONE   = 16'd1;

    logic          r_rx_meta;
    logic          r_rx_sync;
    uart_state_t   r_state;
    uart_state_t   w_state_next;
    logic [15:0]   r_clk_cnt;
    logic [15:0]   w_clk_cnt_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_frame_err;
    logic          w_frame_err_next;
    logic          r_overrun;
    logic          r_busy;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    assign o_valid     = (w_fifo_count != {CW{1'b0}});
    assign w_pop       = i_ready && !w_fifo_empty;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

    // Line synchronizer, idles high so reset does not fake a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receive FSM state register plus counters and status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_err_next;
            r_busy      <= (w_state_next != ST_IDLE);
            // A new drop wins over a simultaneous clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    // Next-state, sampling and push/drop decisions.
    always_comb begin
        w_state_next     = r_state;
        w_clk_cnt_next   = r_clk_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_frame_err_next = 1'b0;
        w_push           = 1'b0;
        w_drop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    w_clk_cnt_next = 16'd0;
                    w_state_next   = ST_START;
                end else begin
                    w_state_next   = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_clk_cnt == HALF_LAST) begin
                    w_clk_cnt_next = 16'd0;
                    w_bit_idx_next = 3'd0;
                    if (!r_rx_sync) begin
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_shift_next[r_bit_idx] = r_rx_sync;
                    w_clk_cnt_next          = 16'd0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_clk_cnt_next = 16'd0;
                    w_state_next   = ST_IDLE;
                    if (r_rx_sync) begin
                        w_push = 1'b1;
                        w_drop = w_fifo_full && !w_pop;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_clk_cnt_next = 16'd0;
                w_bit_idx_next = 3'd0;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (r_shift_or_next(w_shift_next)),
        .i_pop   (w_pop),
        .o_rdata (o_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The stop-bit push carries the fully assembled byte.
    function automatic logic [7:0] r_shift_or_next(input logic [7:0] shift_val);
        return shift_val;
    endfunction

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (16 clocks per bit, 4-entry FIFO).
module tb_uart_rx_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic       i_ready;
    logic       i_clr;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] rxq[$];
    int valid_cycles;
    int fe_cnt;

    always #5 i_clk = ~i_clk;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clr       (i_clr),
        .o_busy      (o_busy)
    );

    // Record consumed bytes, valid cycles and framing-error pulses.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) rxq.push_back(o_data);
            if (o_valid) valid_cycles++;
            if (o_frame_err) fe_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        rxq.delete();
        valid_cycles = 0;
        fe_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            idle(16);
        end
        i_rx = 1'b1;
    endtask

    // Drive i_ready and/or i_clr high for exactly the stop-bit sampling cycle.
    task automatic strobe_at_stop(input bit do_ready, input bit do_clr);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_busy && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL strobe_wait: busy=%0b, required 1 within 400 cycles", o_busy);
        end else begin
            repeat (151) @(posedge i_clk);
            #2;
            if (do_ready) i_ready = 1'b1;
            if (do_clr) i_clr = 1'b1;
            @(posedge i_clk);
            #2;
            i_ready = 1'b0;
            i_clr = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0; i_clr = 1'b0;
        clear_mon();
        idle(3);
        @(negedge i_clk);
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", o_data); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", o_frame_err); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b, required 0", o_overrun); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        idle(4);
    endtask

    task automatic test_good_frame();
        clear_mon();
        i_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(10);
        checks++; if (rxq.size() !== 1) begin errors++; $display("FAIL a5_count: got %0d bytes, required 1", rxq.size()); end
        if (rxq.size() > 0) begin
            checks++; if (rxq[0] !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h, required a5", rxq[0]); end
        end
        checks++; if (valid_cycles !== 1) begin errors++; $display("FAIL a5_valid_cycles: got %0d, required 1", valid_cycles); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL a5_ferr: got %0d pulses, required 0", fe_cnt); end
        i_ready = 1'b0;
    endtask

    task automatic test_glitch();
        clear_mon();
        i_rx = 1'b0;
        idle(4);
        i_rx = 1'b1;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy=%b, required 1", o_busy); end
        idle(30);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy=%b, required 0", o_busy); end
        checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL glitch_valid: got %0d cycles, required 0", valid_cycles); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses, required 0", fe_cnt); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        i_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        idle(30);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d, required 1", fe_cnt); end
        checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL ferr_valid: got %0d cycles, required 0", valid_cycles); end
        checks++; if (dut.u_fifo.o_count !== 3'd0) begin errors++; $display("FAIL ferr_count: got %0d, required 0", dut.u_fifo.o_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b, required 0", o_busy); end
        i_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] exp [4];
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h04;
        clear_mon();
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
        idle(10);
        checks++; if (dut.u_fifo.o_count !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d, required 4", dut.u_fifo.o_count); end
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, required 1", o_overrun); end
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h01) begin errors++; $display("FAIL ovr_head: valid=%b data=%h, required 1/01", o_valid, o_data); end
        fork
            send_frame(8'h66, 1'b1);
            strobe_at_stop(1'b0, 1'b1);
        join
        idle(10);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_clr_collide: got %b, required 1", o_overrun); end
        i_ready = 1'b1;
        idle(8);
        i_ready = 1'b0;
        checks++; if (rxq.size() !== 4) begin errors++; $display("FAIL ovr_pop_count: got %0d bytes, required 4", rxq.size()); end
        for (int i = 0; i < 4 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== exp[i]) begin errors++; $display("FAIL ovr_pop_data[%0d]: got %h, required %h", i, rxq[i], exp[i]); end
        end
        checks++; if (o_valid !== 1'b0 || o_data !== 8'h04) begin errors++; $display("FAIL ovr_hold: valid=%b data=%h, required 0/04", o_valid, o_data); end
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, required 1", o_overrun); end
        i_clr = 1'b1;
        idle(1);
        i_clr = 1'b0;
        idle(2);
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b, required 0", o_overrun); end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        i_ready = 1'b1;
        i_rx = 1'b0;
        idle(16);
        i_rx = 1'b1;
        idle(56);
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", o_busy); end
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        idle(3);
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", o_busy); end
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        idle(5);
        send_frame(8'h5A, 1'b1);
        idle(10);
        checks++; if (rxq.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d bytes, required 1", rxq.size()); end
        if (rxq.size() > 0) begin
            checks++; if (rxq[0] !== 8'h5A) begin errors++; $display("FAIL mid_data: got %h, required 5a", rxq[0]); end
        end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL mid_ferr: got %0d pulses, required 0", fe_cnt); end
        i_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [5];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h55;
        clear_mon();
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(10);
        checks++; if (dut.u_fifo.o_count !== 3'd4) begin errors++; $display("FAIL full_fill: got %0d, required 4", dut.u_fifo.o_count); end
        fork
            send_frame(8'h55, 1'b1);
            strobe_at_stop(1'b1, 1'b0);
        join
        idle(10);
        checks++; if (dut.u_fifo.o_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, required 4", dut.u_fifo.o_count); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL full_ovr: got %b, required 0", o_overrun); end
        i_ready = 1'b1;
        idle(8);
        i_ready = 1'b0;
        checks++; if (rxq.size() !== 5) begin errors++; $display("FAIL full_pop_count: got %0d bytes, required 5", rxq.size()); end
        for (int i = 0; i < 5 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== exp[i]) begin errors++; $display("FAIL full_order[%0d]: got %h, required %h", i, rxq[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
